// File: rtl/lsu.sv
// Load/store unit: turns ALU address/func3/rs2 into a word-addressed
// req/ack memory access and returns extended load data to write-back.
module lsu #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  a_reset_n,
    input  logic                  lsu_valid,
    input  logic                  lsu_we,
    input  logic [2:0]            func3,
    input  logic [ADDR_WIDTH-1:0] lsu_address,
    input  logic [DATA_WIDTH-1:0] lsu_store_data,
    output logic                  lsu_stall,
    output logic [DATA_WIDTH-1:0] lsu_load_data,
    output logic                  lsu_load_valid,
    output logic                  lsu_misaligned,
    output logic                  lsu_bus_error,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_byte_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Counter holds completed ACCESS cycles, so it needs to reach TIMEOUT_CYCLES-1.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [CNT_W-1:0]      wait_cnt;
    logic [2:0]            func3_q;
    logic [1:0]            addr_lo_q;
    logic                  illegal;
    logic                  misaligned;
    logic                  accept;
    logic                  timeout;
    logic [3:0]            byte_en_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;

    // Legality/alignment check and the combinational handshake to the core.
    always_comb begin
        illegal    = (func3 == 3'b011) || (func3[2:1] == 2'b11) || (lsu_we && func3[2]);
        misaligned = ((func3[1:0] == 2'b01) && lsu_address[0])
                  || ((func3[1:0] == 2'b10) && (lsu_address[1:0] != 2'b00));
        lsu_misaligned = (state == ST_IDLE) && lsu_valid && (illegal || misaligned);
        accept         = (state == ST_IDLE) && lsu_valid && !(illegal || misaligned);
        lsu_stall      = accept || (state == ST_ACCESS);
        timeout        = (state == ST_ACCESS) && (TIMEOUT_CYCLES != 0) && !mem_ack
                      && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Byte-lane enables and lane-replicated store data for the accepted access.
    always_comb begin
        byte_en_nxt = 4'b1111;
        wdata_nxt   = lsu_store_data;
        case (func3[1:0])
            2'b00: begin
                byte_en_nxt = 4'b0001 << lsu_address[1:0];
                wdata_nxt   = {4{lsu_store_data[7:0]}};
            end
            2'b01: begin
                byte_en_nxt = 4'b0011 << {lsu_address[1], 1'b0};
                wdata_nxt   = {2{lsu_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane extraction and sign/zero extension of the returning read data.
    always_comb begin
        rd_byte  = mem_rdata[{addr_lo_q, 3'b000} +: 8];
        rd_half  = mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
        load_ext = mem_rdata;
        case (func3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_ext = {24'h000000, rd_byte};
            3'b101:  load_ext = {16'h0000, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
            ST_ACCESS: if (mem_ack || timeout) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!a_reset_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // Memory port, latched access attributes, wait counter and result registers.
    always_ff @(posedge clk) begin
        if (!a_reset_n) begin
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_address    <= '0;
            mem_byte_en    <= 4'b0000;
            mem_wdata      <= '0;
            lsu_load_data  <= '0;
            lsu_load_valid <= 1'b0;
            lsu_bus_error  <= 1'b0;
            wait_cnt       <= '0;
            func3_q        <= 3'b000;
            addr_lo_q      <= 2'b00;
        end else begin
            lsu_load_valid <= 1'b0;
            lsu_bus_error  <= 1'b0;
            if (accept) begin
                mem_req     <= 1'b1;
                mem_we      <= lsu_we;
                mem_address <= {lsu_address[ADDR_WIDTH-1:2], 2'b00};
                mem_byte_en <= byte_en_nxt;
                mem_wdata   <= wdata_nxt;
                func3_q     <= func3;
                addr_lo_q   <= lsu_address[1:0];
                wait_cnt    <= '0;
            end else if (state == ST_ACCESS) begin
                if (mem_ack) begin
                    mem_req <= 1'b0;
                    if (!mem_we) begin
                        lsu_load_data  <= load_ext;
                        lsu_load_valid <= 1'b1;
                    end
                end else if (timeout) begin
                    mem_req       <= 1'b0;
                    lsu_bus_error <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized accesses
// checked against an arithmetic reference model.
module tb_lsu;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        a_reset_n;
    logic        lsu_valid;
    logic        lsu_we;
    logic [2:0]  func3;
    logic [31:0] lsu_address;
    logic [31:0] lsu_store_data;
    logic        lsu_stall;
    logic [31:0] lsu_load_data;
    logic        lsu_load_valid;
    logic        lsu_misaligned;
    logic        lsu_bus_error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_ld = 32'h0;

    lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .a_reset_n(a_reset_n), .lsu_valid(lsu_valid), .lsu_we(lsu_we),
        .func3(func3), .lsu_address(lsu_address), .lsu_store_data(lsu_store_data),
        .lsu_stall(lsu_stall), .lsu_load_data(lsu_load_data), .lsu_load_valid(lsu_load_valid),
        .lsu_misaligned(lsu_misaligned), .lsu_bus_error(lsu_bus_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_address(mem_address),
        .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: access size in bytes, legality, lanes, store data, load result.
    function automatic int unsigned nbytes(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic bit is_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        if (we) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return ok && ((a % nbytes(f3)) == 0);
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned nb = nbytes(f3);
        return 4'(((32'd1 << nb) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int unsigned nb = nbytes(f3);
        if (nb == 1) return (sd & 32'hFF) * 32'h01010101;
        if (nb == 2) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int unsigned nb = nbytes(f3);
        logic [31:0] mask;
        logic [31:0] v;
        if (nb >= 4) return rd;
        mask = (32'd1 << (8 * nb)) - 1;
        v = (rd >> (8 * (a % 4))) & mask;
        if (!f3[2] && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    // One complete access from the core side; ack_delay >= TO means ack is withheld.
    // Entered and left at posedge+1 with lsu_valid=0.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sd, input logic [31:0] rd,
                              input int ack_delay, input bit stray_ack);
        bit legal = is_legal(we, f3, addr);
        bit acked = (ack_delay < int'(TO));
        int fin   = acked ? ack_delay : int'(TO) - 1;
        lsu_valid = 1'b1; lsu_we = we; func3 = f3; lsu_address = addr; lsu_store_data = sd;
        #1;
        chk("misaligned", 32'(lsu_misaligned), 32'(!legal));
        chk("stall_accept", 32'(lsu_stall), 32'(legal));
        if (!legal) begin
            @(posedge clk); #1;
            chk("no_req_illegal", 32'(mem_req), 32'd0);
            lsu_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        chk("mem_address", mem_address, addr & 32'hFFFF_FFFC);
        chk("mem_byte_en", 32'(mem_byte_en), 32'(ref_be(f3, addr)));
        chk("mem_we", 32'(mem_we), 32'(we));
        if (we) chk("mem_wdata", mem_wdata, ref_wdata(f3, sd));
        for (int i = 0; i <= fin; i++) begin
            chk("req_access", 32'(mem_req), 32'd1);
            chk("stall_access", 32'(lsu_stall), 32'd1);
            mem_ack   = (i == ack_delay);
            mem_rdata = (i == ack_delay) ? rd : $urandom;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        if (acked && !we) exp_ld = ref_load(f3, addr, rd);
        chk("stall_done", 32'(lsu_stall), 32'd0);
        chk("req_done", 32'(mem_req), 32'd0);
        chk("load_valid_done", 32'(lsu_load_valid), 32'(acked && !we));
        chk("bus_error_done", 32'(lsu_bus_error), 32'(!acked));
        chk("load_data", lsu_load_data, exp_ld);
        mem_ack   = stray_ack;
        mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        lsu_valid = 1'b0;
        #1;
        chk("load_valid_idle", 32'(lsu_load_valid), 32'd0);
        chk("bus_error_idle", 32'(lsu_bus_error), 32'd0);
        chk("stall_idle", 32'(lsu_stall), 32'd0);
        chk("load_data_hold", lsu_load_data, exp_ld);
    endtask

    initial begin
        a_reset_n = 1'b0; lsu_valid = 1'b0; lsu_we = 1'b0; func3 = 3'd0;
        lsu_address = 32'h0; lsu_store_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_byte_en", 32'(mem_byte_en), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_load_data", lsu_load_data, 32'h0);
        chk("rst_load_valid", 32'(lsu_load_valid), 32'd0);
        chk("rst_bus_error", 32'(lsu_bus_error), 32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        a_reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        chk("lw_value", lsu_load_data, 32'hDEADBEEF);
        run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b0);
        chk("lb_value", lsu_load_data, 32'hFFFFFF80);
        run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b1);
        chk("lbu_value", lsu_load_data, 32'h00000080);
        run_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 2, 1'b0);
        chk("lh_value", lsu_load_data, 32'hFFFF80FF);
        run_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 1'b1);
        chk("sh_hold", lsu_load_data, 32'hFFFF80FF);
        run_access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b0);
        run_access(1'b1, 3'b100, 32'h300, 32'h0, 32'h0, 0, 1'b0);
        run_access(1'b0, 3'b010, 32'h400, 32'h0, 32'h11111111, 20, 1'b1);
        run_access(1'b0, 3'b010, 32'h404, 32'h0, 32'h22222222, int'(TO) - 1, 1'b0);
        chk("ack_on_last", lsu_load_data, 32'h22222222);

        // Reset in the middle of ACCESS, then a late ack.
        lsu_valid = 1'b1; lsu_we = 1'b0; func3 = 3'b010; lsu_address = 32'h500;
        @(posedge clk); #1;
        chk("mid_req", 32'(mem_req), 32'd1);
        a_reset_n = 1'b0;
        @(posedge clk); #1;
        a_reset_n = 1'b1;
        lsu_valid = 1'b0;
        exp_ld    = 32'h0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_stall", 32'(lsu_stall), 32'd0);
        chk("mid_rst_be", 32'(mem_byte_en), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("late_ack_valid", 32'(lsu_load_valid), 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_data", lsu_load_data, 32'h0);

        // Randomized accesses.
        for (int n = 0; n < 80; n++) begin
            logic        rwe;
            logic [2:0]  rf3;
            logic [31:0] raddr;
            int          rdly;
            rwe   = 1'($urandom_range(0, 1));
            rf3   = 3'($urandom_range(0, 7));
            raddr = $urandom;
            if ($urandom_range(0, 3) != 0) raddr = raddr & ~((nbytes(rf3) % 4 == 0 ? 32'd3 : 32'(nbytes(rf3) - 1)));
            rdly  = int'($urandom_range(0, 10));
            run_access(rwe, rf3, raddr, $urandom, $urandom, rdly, bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
